sort_ram_arbiter: RTL

Round-robin arbiter sharing one port of a sort-buffer RAM block among CLIENTS requesters: the packet receive writer, the bubble-sort engine and the packet send reader. It grants at most one access per cycle, supports locked bursts so the sort engine can own the port for a compare/swap sequence, and returns read data tagged to the requesting client after the fixed RAM read latency. It sits between the stream controller and each RAM block instance.

---
 rtl/sort_pkg.sv | 17 +
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/sort_ram_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the sort-buffer RAM slice.
// Client indices fix which requester sits on which arbiter port.
package sort_pkg;

    typedef enum logic {
        IDLE_S,
        LOCKED_S
    } state_t;

    localparam int CLIENT_RX   = 0;
    localparam int CLIENT_SORT = 1;
    localparam int CLIENT_TX   = 2;

    localparam int SORT_DWIDTH = 10;
    localparam int SORT_AWIDTH = 10;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: delay line carrying (valid, client index) alongside
// the RAM read latency so returned data can be steered to its owner.
module rd_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IW    = 2
) (
    input  logic          clk_i,
    input  logic          srst_n_i,
    input  logic          push_valid,
    input  logic [IW-1:0] push_idx,
    output logic          pop_valid,
    output logic [IW-1:0] pop_idx
);

    logic [DEPTH-1:0] v_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i]   <= 1'b0;
                idx_q[i] <= '0;
            end
        end else begin
            v_q[0]   <= push_valid;
            idx_q[0] <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i]   <= v_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign pop_valid = v_q[DEPTH-1];
    assign pop_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/sort_ram_arbiter.sv
// sort_ram_arbiter: round-robin sharing of one sort-buffer RAM port,
// with locked bursts for the sort engine and tagged read returns.
module sort_ram_arbiter
    import sort_pkg::*;
#(
    parameter int DWIDTH     = SORT_DWIDTH,
    parameter int AWIDTH     = SORT_AWIDTH,
    parameter int CLIENTS    = 3,
    parameter int RD_LATENCY = 2,
    parameter int MAX_LOCK   = 64
) (
    input  logic                      clk_i,
    input  logic                      srst_n_i,
    input  logic [CLIENTS-1:0]        req_i,
    input  logic [CLIENTS-1:0]        lock_i,
    input  logic [CLIENTS-1:0]        wr_i,
    input  logic [CLIENTS*AWIDTH-1:0] addr_i,
    input  logic [CLIENTS*DWIDTH-1:0] wdata_i,
    output logic [CLIENTS-1:0]        gnt_o,
    output logic [CLIENTS-1:0]        rvalid_o,
    output logic [DWIDTH-1:0]         rdata_o,
    output logic                      lock_err_o,
    output logic [AWIDTH-1:0]         ram_addr_o,
    output logic [DWIDTH-1:0]         ram_data_o,
    output logic                      ram_wren_o,
    input  logic [DWIDTH-1:0]         ram_q_i
);

    localparam int IW  = $clog2(CLIENTS);
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(MAX_LOCK + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] own_q, own_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_err_q, lock_err_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;

    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW1-1:0] cand_w;
    logic [IW-1:0] cand;
    logic [AWIDTH-1:0] addr_sel;
    logic [DWIDTH-1:0] data_sel;
    logic          wr_sel, lock_sel;
    logic          tag_valid;
    logic [IW-1:0] tag_idx;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] k);
        return (k == IW'(CLIENTS - 1)) ? '0 : k + IW'(1);
    endfunction

    // Owner is the only candidate while locked; otherwise search from rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand_w  = '0;
        cand    = '0;
        if (state_q == LOCKED_S) begin
            gnt_any = req_i[own_q];
            gnt_idx = own_q;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                cand_w = {1'b0, rr_ptr_q} + IW1'(i);
                if (cand_w >= IW1'(CLIENTS))
                    cand_w = cand_w - IW1'(CLIENTS);
                cand = cand_w[IW-1:0];
                if (!gnt_any && req_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        wr_sel   = 1'b0;
        lock_sel = 1'b0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (gnt_idx == IW'(i)) begin
                addr_sel = addr_i[i*AWIDTH +: AWIDTH];
                data_sel = wdata_i[i*DWIDTH +: DWIDTH];
                wr_sel   = wr_i[i];
                lock_sel = lock_i[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        own_d      = own_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (gnt_any) begin
                    if (lock_sel && MAX_LOCK > 1) begin
                        state_d    = LOCKED_S;
                        own_d      = gnt_idx;
                        lock_cnt_d = CW'(1);
                    end else begin
                        rr_ptr_d = rr_next(gnt_idx);
                    end
                end
            end
            LOCKED_S: begin
                lock_cnt_d = lock_cnt_q + CW'(1);
                // lock_cnt counts owned cycles already completed
                if (!lock_i[own_q] || lock_cnt_q == CW'(MAX_LOCK - 1)) begin
                    state_d    = IDLE_S;
                    rr_ptr_d   = rr_next(own_q);
                    lock_cnt_d = '0;
                    lock_err_d = lock_i[own_q];
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q    <= IDLE_S;
            rr_ptr_q   <= '0;
            own_q      <= '0;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            own_q      <= own_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            if (gnt_any) begin
                addr_q <= addr_sel;
                data_q <= data_sel;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .IW    (IW)
    ) u_rd_tag_pipe (
        .clk_i      (clk_i),
        .srst_n_i   (srst_n_i),
        .push_valid (gnt_any && !wr_sel),
        .push_idx   (gnt_idx),
        .pop_valid  (tag_valid),
        .pop_idx    (tag_idx)
    );

    always_comb begin
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        lock_err_o = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wren_o = 1'b0;
        if (srst_n_i) begin
            if (gnt_any)
                gnt_o[gnt_idx] = 1'b1;
            if (tag_valid) begin
                rvalid_o[tag_idx] = 1'b1;
                rdata_o           = ram_q_i;
            end
            lock_err_o = lock_err_q;
            ram_addr_o = gnt_any ? addr_sel : addr_q;
            ram_data_o = gnt_any ? data_sel : data_q;
            ram_wren_o = gnt_any && wr_sel;
        end
    end

endmodule
